// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 index tables, rotation schedule,
// round index type and key-schedule state encoding (FIPS 46-3).
package des_pkg;

    typedef logic [3:0] round_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_t;

    // Entries are 1-based DES bit numbers; bit 1 is the MSB of the source vector.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Rotation amount of each round, indexed by round number minus 1.
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic left,
                                          input logic [1:0] amt);
        logic [27:0] r;
        if (left)
            r = (amt == 2'd2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
        else
            r = (amt == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Purely combinational DES PC-2 permutation: 56-bit C||D to 48-bit round subkey.
// cd[55] is C bit 1; subkey[47] is PC-2 output bit 1.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey[47-i] = cd[56-PC2[i]];
    end

endmodule

// File: rtl/des_key_sched_dec.sv
// Iterative DES key schedule emitting K16..K1 (decryption order), one per handshake.
// Optional DES_KS_ENC_EN adds a mode_enc input selecting K1..K16 (encryption order).
module des_key_sched_dec
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
`ifdef DES_KS_ENC_EN
    input  logic        mode_enc,
`endif
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_last
);

    ks_state_t   state;
    logic [27:0] c;
    logic [27:0] d;
    round_t      round;
    logic        enc;

    logic        mode_sel;
    logic [55:0] pc1_cd;
    round_t      next_idx;
    logic [1:0]  shift_amt;
    logic        final_round;

`ifdef DES_KS_ENC_EN
    assign mode_sel = mode_enc;
`else
    assign mode_sel = 1'b0;
`endif

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_cd[55-i] = key_in[64-PC1[i]];
    end

    // Decryption undoes the shift of the round just shown; encryption applies the next one.
    assign next_idx    = round + 4'd1;
    assign shift_amt   = enc ? SHIFTS[next_idx] : SHIFTS[round];
    assign final_round = enc ? (round == 4'd15) : (round == 4'd0);

    assign key_ready    = (state == ST_IDLE);
    assign subkey_valid = (state == ST_RUN);
    assign subkey_round = round;
    assign subkey_last  = subkey_valid && final_round;

    des_pc2 u_pc2 (
        .cd     ({c, d}),
        .subkey (subkey)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            c     <= '0;
            d     <= '0;
            round <= '0;
            enc   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        enc   <= mode_sel;
                        c     <= mode_sel ? rot28(pc1_cd[55:28], 1'b1, 2'd1) : pc1_cd[55:28];
                        d     <= mode_sel ? rot28(pc1_cd[27:0],  1'b1, 2'd1) : pc1_cd[27:0];
                        round <= mode_sel ? 4'd0 : 4'd15;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (subkey_ready) begin
                        if (final_round) begin
                            state <= ST_IDLE;
                        end else begin
                            c     <= rot28(c, enc, shift_amt);
                            d     <= rot28(d, enc, shift_amt);
                            round <= enc ? next_idx : round - 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Self-checking bench for des_key_sched_dec against a table-driven DES key schedule model.
// Define DES_KS_ENC_EN to also exercise the encryption-order mode.
module tb_des_key_sched_dec;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_KEY = 64'h123456789ABCDEF0;
    localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;
    localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [63:0] key_in;
    logic        subkey_ready;
`ifdef DES_KS_ENC_EN
    logic        mode_enc;
`endif
    logic        key_ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_last;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] ref_k [16];
    logic [47:0] obs_first;
    logic [47:0] obs_last;
    logic [63:0] rk1, rk2;

    des_key_sched_dec dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
`ifdef DES_KS_ENC_EN
        .mode_enc     (mode_enc),
`endif
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_last  (subkey_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference schedule: ref_k[r] holds K(r+1), built by cumulative left rotations.
    function automatic void model(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-T_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < T_SH[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ref_k[r][47-j] = cd[56-T_PC2[j]];
        end
    endfunction

    // Caller presents the key (key_valid=1) at a negedge; this drains all 16 subkeys.
    task automatic run_key(input logic enc, input int stall_pct,
                           input logic offer_next, input logic [63:0] next_key);
        int          got = 0;
        int          budget = 0;
        int          idx;
        logic        stalled = 1'b0;
        logic [47:0] hold_k = '0;
        check("accept_ready", key_ready, 1);
        @(negedge clk);
        if (offer_next) key_in = next_key;
        else            key_valid = 1'b0;
        while (got < 16 && budget < 400) begin
            idx = enc ? got : 15 - got;
            check("run_valid", subkey_valid, 1);
            check("run_subkey", subkey, ref_k[idx]);
            check("run_round", subkey_round, idx);
            check("run_last", subkey_last, (got == 15));
            if (stalled) check("stall_hold", subkey, hold_k);
            if (got == 0)  obs_first = subkey;
            if (got == 15) obs_last  = subkey;
            subkey_ready = ($urandom_range(0, 99) >= stall_pct);
            stalled = !subkey_ready;
            hold_k  = subkey;
            if (subkey_ready) got++;
            budget++;
            @(negedge clk);
        end
        check("run_done", got, 16);
        subkey_ready = 1'b0;
        check("idle_ready", key_ready, 1);
        check("idle_valid", subkey_valid, 0);
    endtask

    initial begin
        rst_n        = 1'b1;
        key_valid    = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b0;
`ifdef DES_KS_ENC_EN
        mode_enc     = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        check("rst_key_ready", key_ready, 1);
        check("rst_valid", subkey_valid, 0);
        check("rst_subkey", subkey, 0);
        check("rst_round", subkey_round, 0);
        check("rst_last", subkey_last, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known answer, no backpressure.
        model(KAT_KEY);
        key_in = KAT_KEY; key_valid = 1'b1;
        run_key(1'b0, 0, 1'b0, '0);
        check("kat_first", obs_first, KAT_K16);
        check("kat_last", obs_last, KAT_K1);

        // Same key under random backpressure.
        key_in = KAT_KEY; key_valid = 1'b1;
        run_key(1'b0, 40, 1'b0, '0);

        // Parity bits flipped: expectations stay those of the KAT key.
        model(KAT_KEY);
        key_in = PAR_KEY; key_valid = 1'b1;
        run_key(1'b0, 25, 1'b0, '0);
        check("par_first", obs_first, KAT_K16);
        check("par_last", obs_last, KAT_K1);

        // Back-to-back random keys; the second is offered throughout the first run.
        rk1 = {$urandom, $urandom};
        rk2 = {$urandom, $urandom};
        model(rk1);
        key_in = rk1; key_valid = 1'b1;
        run_key(1'b0, 30, 1'b1, rk2);
        model(rk2);
        run_key(1'b0, 0, 1'b0, '0);

        // Reset after seven subkeys, then a fresh key.
        rk1 = {$urandom, $urandom};
        model(rk1);
        key_in = rk1; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; subkey_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("mid_round", subkey_round, 8);
        check("mid_subkey", subkey, ref_k[8]);
        subkey_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_key_ready", key_ready, 1);
        check("mid_rst_valid", subkey_valid, 0);
        check("mid_rst_subkey", subkey, 0);
        check("mid_rst_round", subkey_round, 0);
        check("mid_rst_last", subkey_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rk2 = {$urandom, $urandom};
        model(rk2);
        key_in = rk2; key_valid = 1'b1;
        run_key(1'b0, 20, 1'b0, '0);

`ifdef DES_KS_ENC_EN
        model(KAT_KEY);
        mode_enc = 1'b1;
        key_in = KAT_KEY; key_valid = 1'b1;
        run_key(1'b1, 0, 1'b0, '0);
        check("enc_first", obs_first, KAT_K1);
        check("enc_last", obs_last, KAT_K16);
        rk1 = {$urandom, $urandom};
        model(rk1);
        key_in = rk1; key_valid = 1'b1;
        run_key(1'b1, 35, 1'b0, '0);
        mode_enc = 1'b0;
        key_in = rk1; key_valid = 1'b1;
        run_key(1'b0, 10, 1'b0, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
